ov7670_frame_timer: RTL and testbench

Sits in the camera PCLK domain and converts the OV7670 VSYNC/HREF/byte-stream timing into a validated end-of-frame strobe `frame_done`. It is the producer of the `frame_done` signal that the downstream frame-enable gating logic counts on its falling edges, and it also provides line/frame bookkeeping. Only frames with exactly V_ACTIVE lines of exactly H_ACTIVE*BPP bytes generate `frame_done`; malformed frames generate `frame_bad` instead.

---
 rtl/ov7670_frame_timer.sv | 159 +++++++++++++++
 tb/tb_ov7670_frame_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_timer.sv
// OV7670 frame validator in the PCLK domain: checks every frame for exactly V_ACTIVE lines of
// H_ACTIVE*BPP bytes, strobes frame_done for good frames and frame_bad for rejected ones.
module ov7670_frame_timer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BPP      = 2,
    parameter int FD_WIDTH = 4
) (
    input  logic       pclk,
    input  logic       irst_n,
    input  logic       vsync,
    input  logic       href,
    output logic       frame_done,
    output logic       frame_bad,
    output logic [9:0] line_cnt,
    output logic [7:0] frame_cnt
);
    localparam int LINE_LEN = H_ACTIVE * BPP;
    localparam int BC_W     = $clog2(LINE_LEN + 2);
    localparam int FD_W     = (FD_WIDTH > 1) ? $clog2(FD_WIDTH) : 1;

    localparam logic [BC_W-1:0] LEN_V    = BC_W'(LINE_LEN);
    localparam logic [BC_W-1:0] LEN_SAT  = BC_W'(LINE_LEN + 1);
    localparam logic [9:0]      V_ACT_V  = 10'(V_ACTIVE);
    localparam logic [FD_W-1:0] FD_LAST  = FD_W'(FD_WIDTH - 1);

    localparam logic [2:0] WAIT_SYNC = 3'd0;
    localparam logic [2:0] VBLANK    = 3'd1;
    localparam logic [2:0] ACTIVE    = 3'd2;
    localparam logic [2:0] DONE      = 3'd3;
    localparam logic [2:0] TAIL      = 3'd4;

    logic            vs_q_r, vs_q2_r, hr_q_r, hr_q2_r;
    logic            vs_rise_r, hr_fall_r, len_ok_r;
    logic            hr_fall_s;
    logic [BC_W-1:0] byte_cnt_r;
    logic [2:0]      state_r;
    logic            err_r, vs_pend_r;
    logic [FD_W-1:0] fd_cnt_r;
    logic            frame_done_r, frame_bad_r;
    logic [9:0]      line_cnt_r;
    logic [7:0]      frame_cnt_r;
    logic [9:0]      line_inc_s;
    logic            err_line_s;

    assign hr_fall_s  = hr_q2_r & ~hr_q_r;
    assign line_inc_s = (line_cnt_r == 10'h3FF) ? line_cnt_r : line_cnt_r + 10'd1;
    assign err_line_s = err_r | ~len_ok_r;

    // Input synchronisation and registered edge detection (length verdict captured with the fall)
    always_ff @(posedge pclk or negedge irst_n) begin
        if (!irst_n) begin
            vs_q_r    <= 1'b0;
            vs_q2_r   <= 1'b0;
            hr_q_r    <= 1'b0;
            hr_q2_r   <= 1'b0;
            vs_rise_r <= 1'b0;
            hr_fall_r <= 1'b0;
            len_ok_r  <= 1'b0;
        end else begin
            vs_q_r    <= vsync;
            vs_q2_r   <= vs_q_r;
            hr_q_r    <= href;
            hr_q2_r   <= hr_q_r;
            vs_rise_r <= vs_q_r & ~vs_q2_r;
            hr_fall_r <= hr_fall_s;
            len_ok_r  <= (byte_cnt_r == LEN_V);
        end
    end

    // Byte counter: saturates one past the line length so an overlong line never aliases to good
    always_ff @(posedge pclk or negedge irst_n) begin
        if (!irst_n) begin
            byte_cnt_r <= {BC_W{1'b0}};
        end else if ((state_r != ACTIVE) || hr_fall_s) begin
            byte_cnt_r <= {BC_W{1'b0}};
        end else if (hr_q_r && (byte_cnt_r != LEN_SAT)) begin
            byte_cnt_r <= byte_cnt_r + BC_W'(1);
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Frame state machine and output strobes
    always_ff @(posedge pclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r      <= WAIT_SYNC;
            err_r        <= 1'b0;
            vs_pend_r    <= 1'b0;
            fd_cnt_r     <= {FD_W{1'b0}};
            frame_done_r <= 1'b0;
            frame_bad_r  <= 1'b0;
            line_cnt_r   <= 10'd0;
            frame_cnt_r  <= 8'd0;
        end else begin
            frame_bad_r <= 1'b0;
            case (state_r)
                WAIT_SYNC: begin
                    if (vs_rise_r) state_r <= VBLANK;
                end
                VBLANK: begin
                    line_cnt_r <= 10'd0;
                    err_r      <= 1'b0;
                    vs_pend_r  <= 1'b0;
                    if (!vs_q_r) state_r <= ACTIVE;
                end
                ACTIVE: begin
                    if (hr_fall_r && (line_inc_s == V_ACT_V)) begin
                        // The line is counted before any coincident vsync edge is considered
                        line_cnt_r <= line_inc_s;
                        if (!err_line_s) begin
                            state_r      <= DONE;
                            frame_done_r <= 1'b1;
                            fd_cnt_r     <= FD_LAST;
                            frame_cnt_r  <= frame_cnt_r + 8'd1;
                            vs_pend_r    <= vs_rise_r;
                        end else begin
                            frame_bad_r <= 1'b1;
                            state_r     <= vs_rise_r ? VBLANK : TAIL;
                        end
                    end else if (vs_rise_r) begin
                        frame_bad_r <= 1'b1;
                        line_cnt_r  <= 10'd0;
                        err_r       <= 1'b0;
                        state_r     <= VBLANK;
                    end else if (hr_fall_r) begin
                        line_cnt_r <= line_inc_s;
                        err_r      <= err_line_s;
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                DONE: begin
                    if (vs_rise_r) vs_pend_r <= 1'b1;
                    if (fd_cnt_r == {FD_W{1'b0}}) begin
                        frame_done_r <= 1'b0;
                        state_r      <= (vs_pend_r || vs_rise_r) ? VBLANK : TAIL;
                    end else begin
                        fd_cnt_r <= fd_cnt_r - FD_W'(1);
                    end
                end
                TAIL: begin
                    if (hr_fall_r) frame_bad_r <= 1'b1;
                    if (vs_rise_r) state_r <= VBLANK;
                end
                default: begin
                    state_r      <= WAIT_SYNC;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign frame_done = frame_done_r;
    assign frame_bad  = frame_bad_r;
    assign line_cnt   = line_cnt_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_ov7670_frame_timer.sv
// Scoreboard bench for ov7670_frame_timer: a frame-level model queues expected frame_done /
// frame_bad events with their cycle, frame_cnt and line_cnt; a monitor pops and compares them.
module tb_ov7670_frame_timer;
    localparam int H   = 4;
    localparam int V   = 3;
    localparam int B   = 2;
    localparam int FDW = 4;
    localparam int L   = H * B;

    logic       pclk = 1'b0;
    logic       irst_n, vsync, href;
    logic       frame_done, frame_bad;
    logic [9:0] line_cnt;
    logic [7:0] frame_cnt;

    ov7670_frame_timer #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(B), .FD_WIDTH(FDW)) dut (
        .pclk(pclk), .irst_n(irst_n), .vsync(vsync), .href(href),
        .frame_done(frame_done), .frame_bad(frame_bad),
        .line_cnt(line_cnt), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit is_done;
        int cyc;
        int fcnt;
        int lcnt;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  fd_falls = 0;
    int  exp_falls = 0;
    bit  m_armed = 1'b0;
    bit  m_closed = 1'b0;
    int  m_lens[$];
    int  m_good = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input bit d, input int c, input int f, input int l);
        ev_t e;
        e.is_done = d;
        e.cyc     = c;
        e.fcnt    = f;
        e.lcnt    = l;
        exp_q.push_back(e);
    endfunction

    // Model: a vsync edge closes an unfinished frame as bad; lines are judged per frame
    function automatic void model_vsync(input int c);
        if (m_armed && !m_closed) push_ev(1'b0, c + 3, m_good, 0);
        m_armed  = 1'b1;
        m_closed = 1'b0;
        m_lens.delete();
    endfunction

    function automatic void model_line(input int c, input int n);
        bit good;
        if (!m_armed) return;
        if (m_closed) begin
            push_ev(1'b0, c + 3, m_good, V);
            return;
        end
        m_lens.push_back(n);
        if (m_lens.size() == V) begin
            good = 1'b1;
            foreach (m_lens[i]) if (m_lens[i] != L) good = 1'b0;
            if (good) begin
                m_good = (m_good + 1) % 256;
                exp_falls++;
                push_ev(1'b1, c + 3, m_good, V);
            end else begin
                push_ev(1'b0, c + 3, m_good, V);
            end
            m_closed = 1'b1;
        end
    endfunction

    task automatic check_event(input bit is_done);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk(is_done ? "unexpected_frame_done" : "unexpected_frame_bad", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind_is_done", int'(is_done), int'(e.is_done));
            chk("event_cycle", cyc, e.cyc);
            chk("event_frame_cnt", int'(frame_cnt), e.fcnt);
            chk("event_line_cnt", int'(line_cnt), e.lcnt);
        end
    endtask

    // Monitor: sample away from the active edge, pop on every strobe
    logic fd_prev = 1'b0;
    int   fd_len = 0;
    always @(negedge pclk) begin
        if (irst_n !== 1'b1) begin
            fd_prev = 1'b0;
            fd_len  = 0;
        end else begin
            if (frame_done && !fd_prev) begin
                check_event(1'b1);
                chk("frame_bad_with_done_rise", int'(frame_bad), 0);
            end else if (frame_bad) begin
                check_event(1'b0);
            end
            if (frame_done) begin
                fd_len++;
            end else if (fd_prev) begin
                chk("frame_done_width", fd_len, FDW);
                fd_len = 0;
                fd_falls++;
            end
            fd_prev = frame_done;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_line(input int n);
        href = 1'b1;
        repeat (n) tick();
        href = 1'b0;
        model_line(cyc, n);
        repeat ($urandom_range(2, 5)) tick();
    endtask

    task automatic vs_pulse(input bit noise);
        bit nz;
        repeat (6) tick();
        nz = noise && (m_closed || !m_armed);
        vsync = 1'b1;
        model_vsync(cyc);
        if (nz) begin
            href = 1'b1;
            tick();
            tick();
            href = 1'b0;
            repeat (4) tick();
        end else begin
            repeat (6) tick();
        end
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic good_frame();
        vs_pulse(1'b1);
        repeat (V) send_line(L);
    endtask

    task automatic do_reset();
        irst_n = 1'b0;
        #1;
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_frame_bad", int'(frame_bad), 0);
        chk("reset_line_cnt", int'(line_cnt), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        exp_q.delete();
        m_lens.delete();
        m_armed  = 1'b0;
        m_closed = 1'b0;
        m_good   = 0;
        repeat (3) tick();
        irst_n = 1'b1;
        tick();
    endtask

    initial begin
        int nl;
        int r;
        int base_falls;
        int base_good;
        irst_n = 1'b1;
        vsync  = 1'b0;
        href   = 1'b0;
        #2;
        do_reset();

        // href activity before any vsync is ignored
        send_line(L);
        send_line(L - 1);
        chk("wait_sync_line_cnt", int'(line_cnt), 0);

        // Nominal good frame
        good_frame();
        repeat (10) tick();
        chk("nominal_line_cnt", int'(line_cnt), V);

        // Short and long middle lines
        vs_pulse(1'b1);
        send_line(L); send_line(L - 1); send_line(L);
        vs_pulse(1'b1);
        send_line(L); send_line(L + 1); send_line(L);

        // Short frame, then good frame followed by an extra line
        vs_pulse(1'b1);
        send_line(L); send_line(L);
        vs_pulse(1'b1);
        chk("short_frame_line_cnt", int'(line_cnt), 0);
        repeat (V) send_line(L);
        send_line(L);

        // Reset in the middle of line 2; remainder of that frame is ignored
        good_frame();
        vs_pulse(1'b0);
        send_line(L);
        href = 1'b1;
        repeat (3) tick();
        do_reset();
        repeat (L - 3) tick();
        href = 1'b0;
        tick();
        send_line(L);
        base_falls = fd_falls;
        repeat (3) good_frame();
        repeat (12) tick();
        chk("downstream_three_falls", fd_falls - base_falls, 3);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            nl = $urandom_range(1, 4);
            vs_pulse(1'b1);
            for (int i = 0; i < nl; i++) begin
                r = $urandom_range(0, 9);
                send_line((r < 6) ? L : (r < 8) ? L - 1 : (r == 8) ? L + 1 : L + 5);
            end
        end

        // 256 good frames bring frame_cnt back to its starting value
        vs_pulse(1'b0);
        base_good = m_good;
        for (int f = 0; f < 256; f++) good_frame();
        repeat (12) tick();
        chk("frame_cnt_wrap", int'(frame_cnt), base_good);

        repeat (12) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_frame_done_falls", fd_falls, exp_falls);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
